// File: rtl/sync_upcounter.sv
// -----------------------------------------------------------------------------
// sync_upcounter
//   Synchronous modulo-N up counter with terminal-count and sticky wrap flag.
//   The count runs 0 .. MODULO-1 and then wraps back to 0 on the same edge that
//   would otherwise step past MODULO-1. The design has no dead state.
//
// Parameters
//   WIDTH   counter width in bits
//   MODULO  count length, legal range 2 .. 2**WIDTH. Elaboration stops outside it.
//
// Ports
//   clk   in   single clock. All flops update on its rising edge.
//   rst   in   synchronous active-high reset: q=0, ovf=0
//   en    in   count enable
//   clr   in   synchronous clear: q=0, ovf=0. It wins over load and en.
//   load  in   parallel-load strobe        (only with SYNC_UPCOUNTER_LOAD_EN)
//   d     in   [WIDTH] parallel-load value (only with SYNC_UPCOUNTER_LOAD_EN).
//               Values >= MODULO are clamped to MODULO-1.
//   q     out  [WIDTH] registered count
//   qbar  out  [WIDTH] ~q, purely combinational
//   tc    out  terminal count: en && q==MODULO-1. It is high the cycle before a wrap.
//   ovf   out  sticky flag. It is set on a MODULO-1 -> 0 wrap.
//               Only rst or clr clears it.
//
// Configuration
//   SYNC_UPCOUNTER_LOAD_EN  when defined, adds the load/d parallel-load port pair.
//                           When it is absent, the counter behaves the same way
//                           cycle for cycle.
//
// Per-edge priority: rst > clr > load > en.
// -----------------------------------------------------------------------------
module sync_upcounter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
`ifdef SYNC_UPCOUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  // Reject illegal configurations at elaboration time.
  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("sync_upcounter: MODULO=%0d outside legal range 2..2**WIDTH", MODULO);
  end

  // MODULO-1 always fits in WIDTH bits, because MODULO <= 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q,   ovf_d;
  logic             at_max;

  assign at_max = (count_q == MAX_COUNT);

  // Next-state logic. Reset is applied in the register process, so it has
  // top priority over everything computed here.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      // Clear also cancels a wrap due on this edge, so that wrap never sets ovf.
      count_d = '0;
      ovf_d   = 1'b0;
    end
`ifdef SYNC_UPCOUNTER_LOAD_EN
    else if (load) begin
      // Clamp out-of-range load values so q can never exceed MODULO-1.
      // A load leaves ovf untouched.
      count_d = (d > MAX_COUNT) ? MAX_COUNT : d;
    end
`endif
    else if (en) begin
      if (at_max) begin
        count_d = '0;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q    = count_q;
  assign qbar = ~count_q;
  assign tc   = en & at_max;
  assign ovf  = ovf_q;

endmodule

// File: doc/sync_upcounter.md
SYNC_UPCOUNTER -- requirements
Module: sync_upcounter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MODULO, default 16, count length; legal range 2..2**WIDTH; elaboration SHALL fail outside this range.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, count enable.
REQ-006 SHALL have port clr, input, 1, synchronous clear.
REQ-007 SHALL have port q, output, WIDTH, registered count value.
REQ-008 SHALL have port qbar, output, WIDTH, bitwise complement of q.
REQ-009 SHALL have port tc, output, 1, terminal-count/carry-out for cascading.
REQ-010 SHALL have port ovf, output, 1, sticky wrap flag.
REQ-011 SHALL have ports load (input, 1, parallel-load strobe) and d (input, WIDTH, load value) only when SYNC_UPCOUNTER_LOAD_EN is defined.

Function
REQ-012 SHALL count up by one per posedge clk when en=1 and no higher-priority action applies; hold when en=0.
REQ-013 SHALL wrap q from MODULO-1 to 0 in the same cycle as the increment (no dead state); q SHALL never exceed MODULO-1.
REQ-014 SHALL apply per-edge priority rst > clr > load > en.
REQ-015 SHALL drive qbar combinationally as ~q, with no register stage.
REQ-016 SHALL drive tc combinationally high iff en=1 and q==MODULO-1, so that tc is high in the cycle preceding the wrap edge.
REQ-017 SHALL set ovf on the edge where q wraps MODULO-1 -> 0; ovf SHALL stay high until rst or clr.
REQ-018 SHALL, on clr=1, set q=0 and ovf=0 on the next edge regardless of en or an imminent wrap; that wrap SHALL NOT set ovf.
REQ-019 SHALL, with WIDTH=4 and MODULO=16, produce exactly the inverse sequence of a 4-bit down counter: 0,1,...,15,0.
REQ-020 SHALL introduce no ripple or derived clocks: all flops SHALL be clocked by clk only.

Reset
REQ-021 SHALL, on posedge clk with rst=1, set q=0 and ovf=0, hence qbar=all-ones and tc=0; en, clr and load SHALL be ignored.
REQ-022 SHALL allow reset mid-count; counting SHALL resume from 0 on the first edge after rst deasserts with en=1.
REQ-023 SHALL leave outputs undefined before the first reset edge; the bench SHALL NOT check them there.

Configuration
REQ-024 SHALL use macro SYNC_UPCOUNTER_LOAD_EN to compile the parallel-load feature in or out.
REQ-025 SHALL, with the macro defined and load=1 (and rst=0, clr=0), set q=d, clamped to MODULO-1 when d>=MODULO; load SHALL NOT change ovf and SHALL override en.
REQ-026 SHALL, without the macro, have no load or d ports, and the counter SHALL be otherwise cycle-identical.

Verification
REQ-027 SHALL cover this scenario: rst=1 for 1 edge, then en=1 for 20 edges (WIDTH=4, MODULO=16) -> q=0..15,0..3; tc high only while q=15; ovf rises on the 15->0 edge.
REQ-028 SHALL cover this scenario: MODULO=10, en=1 for 12 edges from reset -> q=0..9,0,1; q never reaches 10; qbar=~q on every cycle.
REQ-029 SHALL cover this scenario: q=7 with en toggled 1,0,0,1 -> q=8,8,8,9; tc=0 throughout.
REQ-030 SHALL cover this scenario: q=15, en=1, clr=1 on the same edge -> q=0, ovf=0; then rst=1 at q=5 -> q=0 on the next edge.
REQ-031 SHALL cover this scenario: with SYNC_UPCOUNTER_LOAD_EN defined, MODULO=10, load=1 d=4 en=1 -> q=4; load=1 d=13 -> q=9; then en=1 -> q=0, ovf=1.
